// File: rtl/compare_unit.sv
// compare_unit: multi-cycle MSB-first chunked compare for EQ/NE/LT/GE/LTU/GEU with valid/ready handshakes
// Ports: clk, reset_n (async active-low); in_valid/in_ready, op (funct3), x, y on the input side;
// out_valid/out_ready, flag, result ({(N-1)'b0, flag}) on the output side.
// Optional: define COMPARE_UNIT_EARLY_EXIT_EN to leave BUSY on the first differing chunk.
module compare_unit #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         flag,
  output logic [N-1:0] result
);
  localparam int NC = N / CHUNK;
  localparam int KW = NC > 1 ? $clog2(NC) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t st, nxt;
  logic [N-1:0] xs, ys, sgn;
  logic [2:0] opr;
  logic [KW-1:0] k;
  logic eq_run, lt_run, eq_nx, lt_nx, last, fl;
  logic [CHUNK-1:0] xc, yc;
  // flipping the sign bit turns a signed compare into an unsigned one
  assign sgn = {op[2:1] == 2'b10, {(N-1){1'b0}}};
  // operands shift left each BUSY cycle, so the current chunk is always the top one
  assign xc = xs[N-1 -: CHUNK];
  assign yc = ys[N-1 -: CHUNK];
  assign eq_nx = eq_run && xc == yc;
  assign lt_nx = (eq_run && xc != yc) ? xc < yc : lt_run;
  assign fl = opr == 3'b000 ? eq_nx : opr == 3'b001 ? !eq_nx : opr[2] ? lt_nx ^ opr[0] : 1'b0;
  assign result = {{(N-1){1'b0}}, flag};
`ifdef COMPARE_UNIT_EARLY_EXIT_EN
  assign last = k == '0 || (eq_run && xc != yc);
`else
  assign last = k == '0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= IDLE;
    else st <= nxt;
  always_comb
    nxt = st == IDLE ? (in_valid ? BUSY : IDLE) :
          st == BUSY ? (last ? DONE : BUSY) :
          st == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready  = st == IDLE;
    out_valid = st == DONE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      xs     <= '0;
      ys     <= '0;
      opr    <= '0;
      k      <= '0;
      eq_run <= 1'b0;
      lt_run <= 1'b0;
      flag   <= 1'b0;
    end else if (st == IDLE && in_valid) begin
      xs     <= x ^ sgn;
      ys     <= y ^ sgn;
      opr    <= op;
      k      <= KW'(NC - 1);
      eq_run <= 1'b1;
      lt_run <= 1'b0;
    end else if (st == BUSY) begin
      xs     <= xs << CHUNK;
      ys     <= ys << CHUNK;
      k      <= k - 1'b1;
      eq_run <= eq_nx;
      lt_run <= lt_nx;
      if (last) flag <= fl;
    end
endmodule
